opb_register_ppc2simulink_fifo: RTL

PPC-to-fabric command channel: an OPB slave that accepts 32-bit words written by the PowerPC and queues them in a small FIFO for fabric logic to consume with a valid/read-enable handshake. It is the write-direction counterpart of the simulink2ppc status registers on the same OPB bus. A status word gives software fill level and a sticky overflow flag. One clock domain: fabric consumers run on OPB_Clk.

---
 rtl/opb_register_ppc2simulink_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/opb_register_ppc2simulink_fifo.sv
// rtl/opb_register_ppc2simulink_fifo.sv - OPB slave queueing PPC-written words into a FWFT FIFO for fabric logic
module opb_register_ppc2simulink_fifo #(
    parameter logic [31:0] C_BASEADDR   = 32'h01002300,
    parameter logic [31:0] C_HIGHADDR   = 32'h010023FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6",
    parameter int          C_FIFO_DEPTH = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [31:0]               user_data_out,
    output logic                      user_valid,
    input  logic                      user_rd_en
);
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(C_FIFO_DEPTH);

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [31:0]   be_mask;
    logic [31:0]   merged;
    logic [1:0]    offset;
    logic          in_range, hit, wr, rd;
    logic          push, pop, flush, ovf_clr, full, accept;

    logic [31:0]   mem [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   last_word;
    logic [31:0]   sl_dbus_q;
    logic          xfer_ack;
    logic          served;
    logic          unused_ok;

    // Big-endian bus numbering: bit 0 of the OPB vectors is the MSB of the value.
    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign offset = addr[3:2];

    assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    // served blocks a second hit while a master keeps select high after its ack
    assign hit      = OPB_select & in_range & ~xfer_ack & ~served;
    assign wr       = hit & ~OPB_RNW;
    assign rd       = hit & OPB_RNW;

    assign be_mask = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};
    assign merged  = (wdata & be_mask) | (last_word & ~be_mask);

    assign full    = (count == FULL_CNT);
    assign push    = wr & (offset == 2'd0);
    assign ovf_clr = wr & (offset == 2'd1) & wdata[16] & OPB_BE[1];
    assign flush   = wr & (offset == 2'd2) & wdata[0];
    assign pop     = user_rd_en & (count != '0);
    assign accept  = push & (~full | pop);

    always_comb begin
        rdata = '0;
        case (offset)
            2'd0:    rdata = last_word;
            2'd1:    rdata = 32'(count) | (32'(overflow) << 16);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            last_word <= '0;
            sl_dbus_q <= '0;
            xfer_ack  <= 1'b0;
            served    <= 1'b0;
        end else begin
            xfer_ack  <= hit;
            sl_dbus_q <= rd ? rdata : '0;
            served    <= OPB_select & (served | hit);
            if (push) last_word <= merged;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (accept) begin
                    mem[wr_ptr] <= merged;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(accept) - CW'(pop);
            end
            if (push & full & ~pop) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign Sl_DBus       = sl_dbus_q;
    assign Sl_xferAck    = xfer_ack;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = mem[rd_ptr];
    assign user_valid    = (count != '0);

    assign unused_ok = ^{OPB_seqAddr, addr[1:0], C_FAMILY};
endmodule
